riscv_regfile_sb: RTL

// Parametrised, clocked RISC-V integer register file for the pipelined core; replaces the unclocked non-pipeline register array.

---
 rtl/riscv_regfile_sb.sv | 100 ++++++++++
 1 files changed

// File: rtl/riscv_regfile_sb.sv
// Clocked RISC-V integer register file: NUM_RD bypassed read ports, one byte-enabled
// write port, x0 hardwired to zero, per-register busy scoreboard and post-reset clear sweep.
module riscv_regfile_sb #(
  parameter  int DATA_WIDTH = 32,
  parameter  int NUM_REG    = 32,
  parameter  int NUM_RD     = 2,
  localparam int AW         = $clog2(NUM_REG)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_RD*AW-1:0]         rd_addr,
  output logic [NUM_RD*DATA_WIDTH-1:0] rd_data,
  output logic [NUM_RD-1:0]            rd_busy,
  input  logic                         wr_en,
  input  logic [AW-1:0]                wr_addr,
  input  logic [DATA_WIDTH-1:0]        wr_data,
  input  logic [DATA_WIDTH/8-1:0]      wr_be,
  input  logic                         busy_set,
  input  logic [AW-1:0]                busy_addr,
  output logic                         ready
);

  localparam int NB = DATA_WIDTH / 8;

  localparam logic [1:0] ST_RESET = 2'd0;
  localparam logic [1:0] ST_CLEAR = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;

  logic [1:0]            state;
  logic [AW-1:0]         clr_ptr;
  logic [DATA_WIDTH-1:0] regs [NUM_REG];
  logic [NUM_REG-1:0]    busy;
  logic                  run;
  logic                  do_wr;
  logic [DATA_WIDTH-1:0] wr_merged;

  assign run   = (state == ST_RUN);
  assign do_wr = run && wr_en && (wr_addr != '0);

  // Stored word with the enabled bytes replaced; shared by the write path and the bypass.
  always_comb begin
    wr_merged = regs[wr_addr];
    for (int unsigned k = 0; k < NB; k++) begin
      if (wr_be[k]) wr_merged[k*8 +: 8] = wr_data[k*8 +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= ST_RESET;
      clr_ptr <= '0;
      busy    <= '0;
      ready   <= 1'b0;
    end else begin
      case (state)
        ST_RESET: state <= ST_CLEAR;
        ST_CLEAR: begin
          clr_ptr <= clr_ptr + AW'(1);
          if (clr_ptr == AW'(NUM_REG - 1)) begin
            state <= ST_RUN;
            ready <= 1'b1;
          end
        end
        ST_RUN: begin
          // Set is applied after clear so a same-address set wins.
          if (do_wr) busy[wr_addr] <= 1'b0;
          if (busy_set && (busy_addr != '0)) busy[busy_addr] <= 1'b1;
        end
        default: state <= ST_RESET;
      endcase
    end
  end

  // Storage has no reset of its own; contents survive reset and are zeroed by the sweep.
  always_ff @(posedge clk) begin
    if (reset && (state == ST_CLEAR)) begin
      regs[clr_ptr] <= '0;
    end else if (reset && do_wr) begin
      regs[wr_addr] <= wr_merged;
    end
  end

  always_comb begin
    logic [AW-1:0] a;
    logic          hit;
    rd_data = '0;
    rd_busy = '0;
    a       = '0;
    hit     = 1'b0;
    for (int unsigned i = 0; i < NUM_RD; i++) begin
      a   = rd_addr[i*AW +: AW];
      hit = wr_en && (wr_addr == a);
      if (run && (a != '0)) begin
        rd_data[i*DATA_WIDTH +: DATA_WIDTH] = hit ? wr_merged : regs[a];
        rd_busy[i] = busy[a] && !hit;
      end
    end
  end

endmodule
